add16u_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that time-shares one 16-bit unsigned approximate adder (combinational, 16+16 → 17 bits) among up to NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block registers the winning pair, drives the shared adder, captures its 17-bit output and returns it on a single response channel tagged with the requester index. It sits between accelerator lanes and the single LUT-cheap adder instance, so that only one adder is placed per cluster.

---
 rtl/add16u_share_ctrl.sv | 113 +++++++++++
 tb/tb_add16u_share_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add16u_share_ctrl.sv
// Purpose : round-robin sequencer that time-shares one external 16-bit approximate adder among NREQ requesters.
// Latency : req accept -> rsp_valid two cycles later (one EXEC cycle for the adder path, then RESP).
// Backpr. : rsp_ready low holds RESP indefinitely with all outputs stable; no request is accepted until the response is taken.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot (winner only) in IDLE
//   req_a/req_b           packed operands, requester i at [16i+15:16i]
//   add_a/add_b/add_o     registered operands to / combinational sum from the shared adder
//   rsp_valid/rsp_ready   response handshake; rsp_sum is the captured adder output, rsp_id its owner
//   busy                  high whenever the FSM is not in IDLE
module add16u_share_ctrl #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [15:0]          add_a,
   output logic [15:0]          add_b,
   input  logic [16:0]          add_o,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [16:0]          rsp_sum,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [15:0]     op_a;
   logic [15:0]     op_b;
   logic [IDW-1:0]  op_id;

   logic            gnt_vld;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW-1:0]  cand;

   // Round-robin search: walk offsets from the far end down to 0 so the
   // requester closest to rr_ptr (upward, with wrap) is the one left standing.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IDW'((int'(rr_ptr) + k) % NREQ);
         if (req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && gnt_vld)
         req_ready[gnt_idx] = 1'b1;
   end

   // Adder inputs come straight from registers so the op regs -> adder ->
   // rsp_sum path is a clean register-to-register cycle.
   assign add_a = op_a;
   assign add_b = op_b;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  op_a  <= req_a[16*int'(gnt_idx) +: 16];
                  op_b  <= req_b[16*int'(gnt_idx) +: 16];
                  op_id <= gnt_idx;
                  if (int'(gnt_idx) == NREQ - 1)
                     rr_ptr <= '0;
                  else
                     rr_ptr <= gnt_idx + 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               // Bit-exact capture; any approximation error is the adder's.
               rsp_sum   <= add_o;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_add16u_share_ctrl.sv
// Bench for add16u_share_ctrl: drives a behavioural adder stub (exact or
// lower-part-OR approximate) and checks grants, timing and responses.
module tb_add16u_share_ctrl;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_a;
   logic [16*NREQ-1:0]  req_b;
   logic [15:0]         add_a;
   logic [15:0]         add_b;
   logic [16:0]         add_o;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [16:0]         rsp_sum;
   logic [IDW-1:0]      rsp_id;
   logic                busy;
   bit                  approx_mode;

   int n_pass = 0;
   int n_tot  = 0;

   add16u_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_o(add_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Adder stub: exact 17-bit sum, or an approximate adder whose low nibble
   // is a[3:0]|b[3:0] and whose upper part adds with carry-in a[3]&b[3].
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input bit approx);
      logic [12:0] hi;
      if (!approx) return {1'b0, a} + {1'b0, b};
      hi = {1'b0, a[15:4]} + {1'b0, b[15:4]} + {12'b0, a[3] & b[3]};
      return {hi, a[3:0] | b[3:0]};
   endfunction

   assign add_o = ref_add(add_a, add_b, approx_mode);

   // Reference arbitration: first valid requester at or after ptr, wrapping.
   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      #1;
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // One full transaction with rsp_ready held high: grant, EXEC, RESP, IDLE.
   task automatic run_txn(input string tag, input logic [NREQ-1:0] vmask, input int exp_id,
                          input logic [15:0] ea, input logic [15:0] eb, input logic [16:0] exp_sum);
      bit found = 0;
      rsp_ready = 1'b1;
      for (int w = 0; w < 8 && !found; w++) begin
         cyc();
         req_valid = vmask;
         samp();
         if (req_ready != '0) found = 1;
      end
      if (!found) begin
         chk({tag, "_grant_timeout"}, 0, 1);
         req_valid = '0;
         return;
      end
      chk({tag, "_grant"}, req_ready, 32'(1) << exp_id);
      cyc();
      req_valid = '0;
      samp();
      chk({tag, "_exec_busy"}, busy, 1);
      chk({tag, "_exec_rdy"}, req_ready, 0);
      chk({tag, "_add_ab"}, {add_a, add_b}, {ea, eb});
      cyc();
      samp();
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      chk({tag, "_rsp_id"}, rsp_id, exp_id);
      chk({tag, "_rsp_sum"}, rsp_sum, exp_sum);
      cyc();
      samp();
      chk({tag, "_idle"}, {rsp_valid, busy}, 0);
   endtask

   typedef struct {
      logic [NREQ-1:0] vmask;
      logic [15:0]     a;
      logic [15:0]     b;
      bit              approx;
      int              exp_id;
      logic [16:0]     exp_sum;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int gq[$];
      int gc[$];
      int rid[$];
      logic [16:0] rsum[$];
      int mptr;
      bit seen;

      req_a = '0;
      req_b = '0;
      approx_mode = 0;

      vecs[0] = '{4'b0100, 16'h1234, 16'h0F0F, 0, 2, 17'h02143};
      vecs[1] = '{4'b0100, 16'h1234, 16'h0F0F, 1, 2, 17'h0213F};
      vecs[2] = '{4'b0001, 16'hFFFF, 16'hFFFF, 1, 0, 17'h1FFFF};
      vecs[3] = '{4'b0001, 16'h0000, 16'h0000, 1, 0, 17'h00000};
      vecs[4] = '{4'b1000, 16'h0008, 16'h0008, 1, 3, 17'h00018};
      vecs[5] = '{4'b0010, 16'hFFFF, 16'h0001, 0, 1, 17'h10000};
      vecs[6] = '{4'b0010, 16'h8000, 16'h8000, 1, 1, 17'h10000};

      // Reset state
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      cyc();
      samp();
      chk("rst_outs", {rsp_valid, busy, req_ready}, 0);
      chk("rst_add", {add_a, add_b}, 0);
      chk("rst_rsp", {rsp_sum, rsp_id}, 0);
      cyc();
      rst_n = 1'b1;

      // Table-driven single transactions
      foreach (vecs[v]) begin
         approx_mode = vecs[v].approx;
         set_op(vecs[v].exp_id, vecs[v].a, vecs[v].b);
         run_txn($sformatf("vec%0d", v), vecs[v].vmask, vecs[v].exp_id,
                 vecs[v].a, vecs[v].b, vecs[v].exp_sum);
      end

      // Round-robin with all requesters valid, rsp_ready high
      do_reset();
      approx_mode = 0;
      for (int i = 0; i < NREQ; i++) set_op(i, 16'(i), 16'h0100);
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         cyc();
         req_valid = '1;
         samp();
         for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) begin gq.push_back(i); gc.push_back(c); end
         if (rsp_valid) begin rid.push_back(int'(rsp_id)); rsum.push_back(rsp_sum); end
      end
      cyc();
      req_valid = '0;
      chk("rr_ngrants", gq.size(), 5);
      chk("rr_nrsp", rid.size(), 5);
      for (int k = 0; k < gq.size() && k < 5; k++) begin
         chk($sformatf("rr_order%0d", k), gq[k], k % NREQ);
         if (k > 0) chk($sformatf("rr_spacing%0d", k), gc[k] - gc[k-1], 3);
      end
      for (int k = 0; k < rid.size() && k < 5; k++) begin
         chk($sformatf("rr_rsp_id%0d", k), rid[k], k % NREQ);
         chk($sformatf("rr_rsp_sum%0d", k), rsum[k], 17'h100 + 17'(k % NREQ));
      end

      // Backpressure: response held for 10 cycles, other requesters waiting
      set_op(1, 16'hABCD, 16'h1111);
      rsp_ready = 1'b0;
      cyc();
      req_valid = 4'b0010;
      samp();
      chk("bp_grant", req_ready, 4'b0010);
      cyc();
      req_valid = 4'b1111;
      samp();
      chk("bp_exec_rdy", req_ready, 0);
      cyc();
      samp();
      chk("bp_first", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd1, 17'h0BCDE});
      for (int s = 0; s < 10; s++) begin
         cyc();
         samp();
         chk($sformatf("bp_hold%0d", s), {rsp_valid, busy, rsp_id, rsp_sum}, {2'b11, 2'd1, 17'h0BCDE});
         chk($sformatf("bp_rdy%0d", s), req_ready, 0);
      end
      cyc();
      rsp_ready = 1'b1;
      req_valid = '0;
      samp();
      chk("bp_pre_hs", rsp_valid, 1);
      cyc();
      samp();
      chk("bp_post_hs", {rsp_valid, busy}, 0);
      cyc();
      samp();
      chk("bp_single_hs", rsp_valid, 0);

      // Pointer hold and wrap
      do_reset();
      for (int i = 0; i < NREQ; i++) set_op(i, 16'(16 * i), 16'h0001);
      run_txn("ptr_a", 4'b1000, 3, 16'h0030, 16'h0001, 17'h00031);
      run_txn("ptr_b", 4'b0010, 1, 16'h0010, 16'h0001, 17'h00011);
      run_txn("ptr_c", 4'b1111, 2, 16'h0020, 16'h0001, 17'h00021);
      run_txn("ptr_d", 4'b1000, 3, 16'h0030, 16'h0001, 17'h00031);
      run_txn("ptr_wrap", 4'b1111, 0, 16'h0000, 16'h0001, 17'h00001);

      // Randomized transactions against the reference model
      do_reset();
      mptr = 0;
      for (int t = 0; t < 30; t++) begin
         logic [NREQ-1:0] m;
         logic [15:0] ra[NREQ];
         logic [15:0] rb[NREQ];
         int g;
         m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            set_op(i, ra[i], rb[i]);
         end
         approx_mode = bit'($urandom_range(0, 1));
         g = rr_pick(m, mptr);
         run_txn($sformatf("rnd%0d", t), m, g, ra[g], rb[g], ref_add(ra[g], rb[g], approx_mode));
         mptr = (g + 1) % NREQ;
      end

      // Reset asserted during EXEC
      approx_mode = 0;
      set_op(0, 16'h5555, 16'h2222);
      rsp_ready = 1'b1;
      cyc();
      req_valid = 4'b0001;
      samp();
      chk("abort_grant", req_ready, 4'b0001);
      cyc();
      req_valid = '0;
      samp();
      chk("abort_in_exec", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_rst_ctl", {rsp_valid, busy, req_ready}, 0);
      chk("abort_rst_dat", {add_a, add_b, rsp_sum, rsp_id}, 0);
      cyc();
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         cyc();
         samp();
         if (rsp_valid || busy) seen = 1;
      end
      chk("abort_no_rsp", seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
